// File: rtl/descriptor_streamer_pkg.sv
// Shared constants for the EP0 descriptor data-stage streamer: FSM state
// codes, default packet size and USB data PIDs.
package descriptor_streamer_pkg;

  localparam int MAX_PKT_DEF = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_IN  = 3'd1;
  localparam logic [2:0] ST_FETCH    = 3'd2;
  localparam logic [2:0] ST_SEND     = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK = 3'd4;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  function automatic logic [3:0] next_pid(input logic [3:0] pid);
    return (pid == PID_DATA1) ? PID_DATA0 : PID_DATA1;
  endfunction

endpackage

// File: rtl/descriptor_streamer_if.sv
// Byte stream from the descriptor streamer to the TX packetiser.
interface descriptor_streamer_if;

  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_zlp;
  logic       tx_pid_data1;

  modport master (
    output tx_valid, tx_data, tx_last, tx_zlp, tx_pid_data1,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, tx_data, tx_last, tx_zlp, tx_pid_data1,
    output tx_ready
  );

endinterface

// File: rtl/descriptor_streamer.sv
// EP0 IN data-stage engine: walks the descriptor ROM in max-packet chunks,
// handles DATA0/DATA1 toggling, retransmission and the trailing ZLP.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | no data stage active, waiting for start
// ST_WAIT_IN  | waiting for an IN token for the next packet
// ST_FETCH    | ROM read in flight for the current byte
// ST_SEND     | byte or ZLP presented to the transmitter
// ST_WAIT_ACK | packet sent, waiting for host ACK (or a repeated IN)
module descriptor_streamer
  import descriptor_streamer_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 16,
  parameter int MAX_PKT = MAX_PKT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [LEN_W-1:0]     desc_len,
  input  logic [LEN_W-1:0]     req_len,
  input  logic                 abort,
  input  logic                 pkt_req,
  input  logic                 pkt_ack,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [7:0]           rom_data,
  descriptor_streamer_if.master tx,
  output logic                 busy,
  output logic                 done
);

  localparam int PKT_LOG = $clog2(MAX_PKT);
  localparam int PKT_W   = PKT_LOG + 1;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  remaining;
  logic [PKT_W-1:0]  pkt_len;
  logic [PKT_W-1:0]  cnt;
  logic [3:0]        cur_pid;
  logic              zlp_pend;
  logic              cur_zlp;

  logic [LEN_W-1:0]  total;
  logic [PKT_W-1:0]  next_len;
  logic [LEN_W-1:0]  rem_after;
  logic              last_byte;

  always_comb begin
    total     = (desc_len < req_len) ? desc_len : req_len;
    next_len  = (remaining >= LEN_W'(MAX_PKT)) ? PKT_W'(MAX_PKT) : remaining[PKT_W-1:0];
    rem_after = remaining - LEN_W'(pkt_len);
    last_byte = cur_zlp || (cnt == pkt_len - PKT_W'(1));
  end

  assign tx.tx_valid     = (state == ST_SEND);
  assign tx.tx_data      = rom_data;
  assign tx.tx_last      = (state == ST_SEND) && last_byte;
  assign tx.tx_zlp       = (state == ST_SEND) && cur_zlp;
  assign tx.tx_pid_data1 = (cur_pid == PID_DATA1);
  assign busy            = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      base      <= '0;
      remaining <= '0;
      pkt_len   <= '0;
      cnt       <= '0;
      cur_pid   <= PID_DATA0;
      zlp_pend  <= 1'b0;
      cur_zlp   <= 1'b0;
      rom_addr  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              base      <= start_addr;
              remaining <= total;
              cur_pid   <= PID_DATA1;
              // A short transfer ending on a packet boundary needs a ZLP
              zlp_pend  <= (total < req_len) && (total[PKT_LOG-1:0] == '0);
              if (total == '0 && req_len == '0) done <= 1'b1;
              else                              state <= ST_WAIT_IN;
            end
          end
          ST_WAIT_IN: begin
            if (pkt_req) begin
              pkt_len <= next_len;
              cnt     <= '0;
              if (next_len == '0) begin
                cur_zlp <= 1'b1;
                state   <= ST_SEND;
              end else begin
                cur_zlp  <= 1'b0;
                rom_addr <= base;
                state    <= ST_FETCH;
              end
            end
          end
          ST_FETCH: state <= ST_SEND;
          ST_SEND: begin
            if (tx.tx_ready) begin
              if (last_byte) begin
                state <= ST_WAIT_ACK;
              end else begin
                cnt      <= cnt + PKT_W'(1);
                rom_addr <= base + ADDR_W'(cnt) + ADDR_W'(1);
                state    <= ST_FETCH;
              end
            end
          end
          ST_WAIT_ACK: begin
            if (pkt_ack) begin
              base      <= base + ADDR_W'(pkt_len);
              remaining <= rem_after;
              cur_pid   <= next_pid(cur_pid);
              if (cur_zlp || (rem_after == '0 && !zlp_pend)) begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end else begin
                if (rem_after == '0) zlp_pend <= 1'b0;
                state <= ST_WAIT_IN;
              end
            end else if (pkt_req) begin
              // Host missed our data: replay the same packet, same PID
              cnt <= '0;
              if (cur_zlp) begin
                state <= ST_SEND;
              end else begin
                rom_addr <= base;
                state    <= ST_FETCH;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/descriptor_streamer.md
Name: descriptor_streamer

Overview:
Control-endpoint IN data-stage engine for the USB FS device. It walks the descriptor ROM from a start address, splits the descriptor into max-packet-size chunks and hands bytes to the packet transmitter with a valid/ready handshake. It tracks DATA0/DATA1 toggling, retransmits on a repeated IN, and sends a zero-length packet where USB requires one. It sits between the SETUP decoder (upstream, supplies start/len) and the ROM plus TX packetiser (downstream).

Parameters:
ADDR_W, 10, ROM address width (1024 x 8 ROM)
LEN_W, 16, width of descriptor/request length fields
MAX_PKT, 8, EP0 max packet size in bytes (power of two, 8..64)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin data stage (accepted only in IDLE)
start_addr  in  ADDR_W  ROM address of first descriptor byte
desc_len  in  LEN_W  actual descriptor length
req_len  in  LEN_W  wLength from SETUP
abort  in  1  new SETUP/bus reset: cancel immediately
pkt_req  in  1  one-cycle pulse: IN token addressed to EP0, transmitter idle
pkt_ack  in  1  one-cycle pulse: host ACKed the last packet
rom_addr  out  ADDR_W  registered ROM address
rom_data  in  8  ROM output (1-cycle registered read)
tx_valid  out  1  byte/ZLP presented
tx_ready  in  1  transmitter accepts
tx_data  out  8  = rom_data (combinational); meaningful only while tx_valid & !tx_zlp
tx_last  out  1  last byte of packet (qualified by tx_valid)
tx_zlp  out  1  zero-length packet (with tx_valid, tx_last=1)
tx_pid_data1  out  1  1=DATA1, 0=DATA0 for current packet
busy  out  1  not IDLE
done  out  1  one-cycle pulse: final packet ACKed

Behaviour:
- Reset (async, rst_n=0): state IDLE; rom_addr=0, tx_valid=0, tx_last=0, tx_zlp=0, tx_pid_data1=0, busy=0, done=0.
- start in IDLE: total=min(desc_len,req_len); base=start_addr; remaining=total; toggle=1 (first data packet DATA1); zlp_pend=(total<req_len)&&(total%MAX_PKT==0). total==0 && req_len==0 -> done pulse next cycle, stay IDLE. Else -> WAIT_IN.
- WAIT_IN: on pkt_req: pkt_len=min(remaining,MAX_PKT), cnt=0. pkt_len==0 -> SEND with tx_zlp=1, tx_last=1. Else rom_addr<=base -> FETCH.
- FETCH: exactly one cycle (ROM read latency); rom_addr held -> SEND.
- SEND: tx_valid=1, tx_last=(cnt==pkt_len-1), tx_pid_data1=toggle. All outputs stable until tx_ready. On tx_valid&tx_ready: last byte/ZLP -> WAIT_ACK; else cnt++, rom_addr<=base+cnt+1 -> FETCH. Throughput: one byte per 2 cycles min.
- WAIT_ACK: pkt_ack -> base+=pkt_len, remaining-=pkt_len, toggle flips. Then: if packet was ZLP, or remaining==0 && !zlp_pend -> done pulse, IDLE. If remaining==0 && zlp_pend -> clear zlp_pend, WAIT_IN. Else WAIT_IN. pkt_req in WAIT_ACK (host missed data) -> retransmit same packet: same base, same toggle, cnt=0.
- pkt_ack outside WAIT_ACK and pkt_req outside WAIT_IN/WAIT_ACK: ignored.
- abort: any state -> IDLE next edge, tx_valid=0, no done; abort beats simultaneous start/pkt_ack. start while busy: ignored.
- Arithmetic: base wraps modulo 2^ADDR_W; remaining never underflows (pkt_len<=remaining).

Decomposition:
- usb_pkg: MAX_PKT default, streamer state enum (IDLE, WAIT_IN, FETCH, SEND, WAIT_ACK), PID constants DATA0/DATA1.
- No sub-module; single FSM plus counters. Bench instantiates the existing descriptor ROM for rom_data.

Test Plan:
- start_addr=0, desc_len=18, req_len=64, tx_ready=1, ACK each -> packets of 8,8,2 bytes = ROM[0..17], PIDs DATA1,DATA0,DATA1, no ZLP, one done.
- desc_len=16, req_len=64 -> packets 8,8 then ZLP (tx_zlp=1, DATA1), done only after ZLP ACKed.
- desc_len=18, req_len=8 -> single 8-byte DATA1 packet, done after its ACK; desc_len=16, req_len=16 -> no ZLP.
- Second pkt_req instead of pkt_ack after packet 1 -> identical 8 bytes resent with DATA1; then ACK -> next packet DATA0 from ROM[8].
- tx_ready randomly low 50% -> tx_data/tx_last/tx_pid_data1 stable while tx_valid&!tx_ready; byte sequence unchanged.
- abort mid-SEND of packet 2 -> tx_valid=0, busy=0 next cycle, no done; following start runs cleanly from DATA1.
